// File: rtl/operand_fetch_pkg.sv
// Shared instruction-format definitions for the operand fetch stage and ALU wrapper:
// field positions, opcode encodings, register-file geometry and the issue decoder.
package operand_fetch_pkg;

    localparam int DATA_W   = 16;
    localparam int INST_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    // Field positions inside the instruction word
    localparam int OP_LSB  = 14;   // op   [15:14]
    localparam int RA_LSB  = 11;   // Ra/Rs [13:11]
    localparam int RB_LSB  = 8;    // Rb/Rd [10:8]
    localparam int OP3_LSB = 4;    // op3  [7:4]
    localparam int D8_LSB  = 0;    // d8   [7:0]
    localparam int D4_LSB  = 0;    // d4   [3:0]

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_IMM = 2'b10,
        OP_ALU = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        OP3_ADD = 4'b0000,
        OP3_SUB = 4'b0001,
        OP3_AND = 4'b0010,
        OP3_OR  = 4'b0011,
        OP3_XOR = 4'b0100,
        OP3_CMP = 4'b0101,
        OP3_MOV = 4'b0110,
        OP3_SLL = 4'b1000,
        OP3_SLR = 4'b1001,
        OP3_SRL = 4'b1010,
        OP3_SRA = 4'b1011,
        OP3_IN  = 4'b1100,
        OP3_OUT = 4'b1101,
        OP3_HLT = 4'b1111
    } op3_e;

    // Source selection for operand B
    typedef enum logic [1:0] {
        BR_REG = 2'b00,
        BR_D4  = 2'b01,
        BR_D8  = 2'b10
    } br_sel_e;

    // Everything the issue logic needs to know about one instruction
    typedef struct packed {
        logic [REG_AW-1:0] ra;       // [13:11] field
        logic [REG_AW-1:0] rb;       // [10:8] field
        logic              use_rb;   // [10:8] register is a checked source
        logic              use_ra;   // [13:11] register is a checked source
        logic              has_dst;
        logic [REG_AW-1:0] dst;
        logic              ar_zero;  // operand A is constant zero
        br_sel_e           br_sel;
        logic              is_st;    // drive store data
        logic [DATA_W-1:0] d8_sext;
        logic [DATA_W-1:0] d4_zext;
    } dec_t;

    function automatic dec_t decode(input logic [INST_W-1:0] inst);
        dec_t       d;
        logic [1:0] op;
        logic [3:0] op3;
        op        = inst[OP_LSB +: 2];
        op3       = inst[OP3_LSB +: 4];
        d         = '0;
        d.ra      = inst[RA_LSB +: REG_AW];
        d.rb      = inst[RB_LSB +: REG_AW];
        d.br_sel  = BR_D8;
        d.d8_sext = {{(DATA_W-8){inst[D8_LSB+7]}}, inst[D8_LSB +: 8]};
        d.d4_zext = {{(DATA_W-4){1'b0}}, inst[D4_LSB +: 4]};
        case (op)
            OP_ALU: begin
                d.dst    = d.rb;
                d.br_sel = BR_REG;
                if (op3 inside {OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA}) begin
                    d.br_sel = BR_D4;
                    d.use_rb = 1'b1;
                end else if (!(op3 inside {OP3_IN, OP3_HLT})) begin
                    d.use_rb = 1'b1;
                    d.use_ra = 1'b1;
                end
                d.has_dst = op3 inside {OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR,
                                        OP3_MOV, OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA,
                                        OP3_IN};
            end
            OP_LD: begin
                d.use_rb  = 1'b1;
                d.has_dst = 1'b1;
                d.dst     = d.ra;
            end
            OP_ST: begin
                d.use_rb = 1'b1;
                d.use_ra = 1'b1;
                d.is_st  = 1'b1;
            end
            default: begin
                // Immediate group: only LI (Ra field zero) writes, into Rb
                d.ar_zero = 1'b1;
                d.has_dst = (d.ra == '0);
                d.dst     = d.rb;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// 8x16 general register file: two operand read ports, one store-data read port,
// one write port. Reads see a same-cycle write (write-through bypass).
module regfile
    import operand_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [REG_AW-1:0] i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic [REG_AW-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic [REG_AW-1:0] i_rd_addr_s,
    output logic [DATA_W-1:0] o_rd_data_s
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    // Register write; reset clears every register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Reads with bypass from the write port
    always_comb begin
        o_rd_data_a = r_regs[i_rd_addr_a];
        o_rd_data_b = r_regs[i_rd_addr_b];
        o_rd_data_s = r_regs[i_rd_addr_s];
        if (i_wr_en && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr_s)) o_rd_data_s = i_wr_data;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes an instruction, reads operands with write-back bypass,
// stalls on scoreboard hazards and presents a registered bundle to the ALU wrapper.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] ir_data,
    output logic [DATA_W-1:0] ar,
    output logic [DATA_W-1:0] br,
    output logic [DATA_W-1:0] sdata,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    dec_t                w_dec;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;
    logic [DATA_W-1:0]   w_rd_s;
    logic [NUM_REGS-1:0] w_wb_mask;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic                w_hazard;
    logic                w_accept;
    logic [DATA_W-1:0]   w_ar;
    logic [DATA_W-1:0]   w_br;
    logic [DATA_W-1:0]   w_sd;

    logic [NUM_REGS-1:0] r_pend;
    logic                r_out_valid;
    logic [INST_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_ar;
    logic [DATA_W-1:0]   r_br;
    logic [DATA_W-1:0]   r_sd;

    assign w_dec = decode(in_inst);

    // Port A always reads the [10:8] field, ports B and S the [13:11] field
    regfile u_regfile (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_wr_en     (wb_en),
        .i_wr_addr   (wb_addr),
        .i_wr_data   (wb_data),
        .i_rd_addr_a (w_dec.rb),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (w_dec.ra),
        .o_rd_data_b (w_rd_b),
        .i_rd_addr_s (w_dec.ra),
        .o_rd_data_s (w_rd_s)
    );

    // Hazard check: a pending register is only free if it is written back right now
    always_comb begin
        w_wb_mask = '0;
        if (wb_en) w_wb_mask[wb_addr] = 1'b1;
        w_busy   = r_pend & ~w_wb_mask;
        w_hazard = (w_dec.use_rb  && w_busy[w_dec.rb])
                || (w_dec.use_ra  && w_busy[w_dec.ra])
                || (w_dec.has_dst && w_busy[w_dec.dst]);
        in_ready = !w_hazard && (!r_out_valid || out_ready);
        w_accept = in_valid && in_ready;
        w_set_mask = '0;
        if (w_accept && w_dec.has_dst) w_set_mask[w_dec.dst] = 1'b1;
    end

    // Operand muxing for the bundle being issued
    always_comb begin
        w_ar = w_dec.ar_zero ? '0 : w_rd_a;
        case (w_dec.br_sel)
            BR_REG:  w_br = w_rd_b;
            BR_D4:   w_br = w_dec.d4_zext;
            default: w_br = w_dec.d8_sext;
        endcase
        w_sd = w_dec.is_st ? w_rd_s : '0;
    end

    // Scoreboard: write-back clears, a same-cycle issue to the same register wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_wb_mask) | w_set_mask;
        end
    end

    // Output bundle register: load on accept, hold while the ALU stalls
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_ir        <= '0;
            r_ar        <= '0;
            r_br        <= '0;
            r_sd        <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_ir        <= in_inst;
            r_ar        <= w_ar;
            r_br        <= w_br;
            r_sd        <= w_sd;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ir_data   = r_ir;
    assign ar        = r_ar;
    assign br        = r_br;
    assign sdata     = r_sd;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, a behavioural reference model, a per-cycle
// compare process and literal checks on hand-computed values.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] ir_data, ar, br, sdata;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;

    int checks = 0;
    int failures = 0;

    operand_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .ir_data(ir_data), .ar(ar), .br(br), .sdata(sdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [15:0] m_regs [8];
    bit          m_pend [8];
    bit          m_ov;
    logic [15:0] m_ir, m_ar, m_br, m_sd;

    function automatic logic [15:0] rdv(input int r);
        if (wb_en && int'(wb_addr) == r) return wb_data;
        return m_regs[r];
    endfunction

    // What an instruction reads/writes and what operands it produces
    function automatic void mdec(input logic [15:0] x, output bit [7:0] need, output int dst,
                                 output logic [15:0] a, output logic [15:0] b, output logic [15:0] s);
        int op, ra, rb, f, d8;
        logic [15:0] imm8;
        op = int'(x[15:14]); ra = int'(x[13:11]); rb = int'(x[10:8]);
        f = int'(x[7:4]); d8 = int'(x[7:0]);
        imm8 = (d8 >= 128) ? 16'(d8 + 16'hFF00) : 16'(d8);
        need = '0; dst = -1; s = '0; a = '0; b = imm8;
        case (op)
            3: begin
                a = rdv(rb);
                if (f >= 8 && f <= 11) begin
                    b = 16'(x[3:0]); need[rb] = 1'b1;
                end else begin
                    b = rdv(ra);
                    if (!(f == 12 || f == 15)) begin need[rb] = 1'b1; need[ra] = 1'b1; end
                end
                if (f <= 4 || f == 6 || (f >= 8 && f <= 12)) dst = rb;
            end
            0: begin a = rdv(rb); need[rb] = 1'b1; dst = ra; end
            1: begin a = rdv(rb); need[rb] = 1'b1; need[ra] = 1'b1; s = rdv(ra); end
            default: if (ra == 0) dst = rb;
        endcase
        if (dst >= 0) need[dst] = 1'b1;
    endfunction

    function automatic bit m_rdy();
        bit [7:0] need; int dst; logic [15:0] a, b, s;
        bit haz = 1'b0;
        mdec(in_inst, need, dst, a, b, s);
        for (int r = 0; r < 8; r++)
            if (need[r] && m_pend[r] && !(wb_en && int'(wb_addr) == r)) haz = 1'b1;
        return !haz && (!m_ov || out_ready);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
            m_ov = 1'b0; m_ir = '0; m_ar = '0; m_br = '0; m_sd = '0;
        end else begin
            bit [7:0] need; int dst; logic [15:0] a, b, s; bit acc;
            mdec(in_inst, need, dst, a, b, s);
            acc = in_valid && m_rdy();
            if (acc) begin
                m_ov = 1'b1; m_ir = in_inst; m_ar = a; m_br = b; m_sd = s;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (wb_en) begin m_regs[wb_addr] = wb_data; m_pend[wb_addr] = 1'b0; end
            if (acc && dst >= 0) m_pend[dst] = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (reset_n) begin
            chk("cmp_in_ready", 16'(in_ready), 16'(m_rdy()));
            chk("cmp_out_valid", 16'(out_valid), 16'(m_ov));
            chk("cmp_ir", ir_data, m_ir);
            chk("cmp_ar", ar, m_ar);
            chk("cmp_br", br, m_br);
            chk("cmp_sdata", sdata, m_sd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic setin(input bit v, input logic [15:0] i, input bit ordy,
                         input bit we, input logic [2:0] wa, input logic [15:0] wd);
        in_valid = v; in_inst = i; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic wb(input logic [2:0] wa, input logic [15:0] wd);
        setin(1'b0, 16'h0000, 1'b1, 1'b1, wa, wd); tick();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_ar", ar, 16'h0);
        chk("rst_br", br, 16'h0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_in_ready", 16'(in_ready), 16'h1);

        // preload (no register pending: write only)
        wb(3'd1, 16'd5); wb(3'd2, 16'd7); wb(3'd4, 16'h0100);
        wb(3'd6, 16'hBEEF); wb(3'd7, 16'h0042);

        // ADD Rs=1, Rd=2
        setin(1'b1, 16'hCA00, 1'b1, 1'b0, 3'd0, 16'h0); tick();
        chk("add_valid", 16'(out_valid), 16'h1);
        chk("add_ar", ar, 16'h0007);
        chk("add_br", br, 16'h0005);
        chk("add_ir", ir_data, 16'hCA00);
        chk("model_add_br", m_br, 16'h0005);
        wb(3'd2, 16'd12);

        // LD R3,-2(R4)
        setin(1'b1, 16'h1CFE, 1'b1, 1'b0, 3'd0, 16'h0); tick();
        chk("ld_ar", ar, 16'h0100);
        chk("ld_br", br, 16'hFFFE);
        chk("ld_sdata", sdata, 16'h0000);

        // ADD reading R3 stalls until write-back
        setin(1'b1, 16'hD900, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("stall_rdy0", 16'(in_ready), 16'h0);
        tick();
        #1 chk("stall_rdy1", 16'(in_ready), 16'h0);
        tick();
        setin(1'b1, 16'hD900, 1'b1, 1'b1, 3'd3, 16'h1234);
        #1 chk("wb_release_rdy", 16'(in_ready), 16'h1);
        tick();
        chk("bypass_br", br, 16'h1234);
        chk("bypass_ar", ar, 16'h0005);

        // issue to R3 while R3 (not pending) is written back: set wins
        setin(1'b1, 16'h1CFE, 1'b1, 1'b1, 3'd3, 16'h5555);
        #1 chk("setclr_rdy", 16'(in_ready), 16'h1);
        tick();
        setin(1'b1, 16'hD800, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("set_wins_rdy", 16'(in_ready), 16'h0);
        tick();

        // HLT ignores pending sources (R1, R3 both pending)
        setin(1'b1, 16'hD9F0, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("hlt_rdy", 16'(in_ready), 16'h1);
        tick();
        chk("hlt_ar", ar, 16'h0005);
        chk("hlt_br", br, 16'h5555);
        wb(3'd3, 16'h0333); wb(3'd1, 16'h0011);

        // LI R5,#9 then backpressure
        setin(1'b1, 16'h8509, 1'b1, 1'b0, 3'd0, 16'h0); tick();
        setin(1'b1, 16'h8801, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_rdy", 16'(in_ready), 16'h0);
            tick();
            chk("bp_valid", 16'(out_valid), 16'h1);
            chk("bp_ir", ir_data, 16'h8509);
            chk("bp_br", br, 16'h0009);
            chk("bp_ar", ar, 16'h0000);
        end
        setin(1'b1, 16'h8801, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("b2b_rdy0", 16'(in_ready), 16'h1);
        tick();
        chk("b2b_ir0", ir_data, 16'h8801);
        chk("b2b_br0", br, 16'h0001);
        setin(1'b1, 16'h8802, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("b2b_rdy1", 16'(in_ready), 16'h1);
        tick();
        chk("b2b_valid1", 16'(out_valid), 16'h1);
        chk("b2b_ir1", ir_data, 16'h8802);
        wb(3'd5, 16'h0030);

        // SLL R5,#3
        setin(1'b1, 16'hC583, 1'b1, 1'b0, 3'd0, 16'h0); tick();
        chk("sll_ar", ar, 16'h0030);
        chk("sll_br", br, 16'h0003);
        // ST R6,4(R7)
        setin(1'b1, 16'h7704, 1'b1, 1'b0, 3'd0, 16'h0); tick();
        chk("st_ar", ar, 16'h0042);
        chk("st_br", br, 16'h0004);
        chk("st_sdata", sdata, 16'hBEEF);
        // ST set nothing pending: reader/writer of R6,R7 issues at once
        setin(1'b1, 16'hF700, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("st_nopend_rdy", 16'(in_ready), 16'h1);
        tick();
        chk("after_st_br", br, 16'hBEEF);
        wb(3'd5, 16'h0000); wb(3'd7, 16'h0000);

        // reset while a bundle is held and R2 is pending
        setin(1'b1, 16'hCA00, 1'b0, 1'b0, 3'd0, 16'h0); tick();
        chk("pre_rst_valid", 16'(out_valid), 16'h1);
        setin(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(out_valid), 16'h0);
        chk("midrst_ar", ar, 16'h0);
        chk("midrst_br", br, 16'h0);
        chk("midrst_ir", ir_data, 16'h0);
        chk("midrst_sdata", sdata, 16'h0);
        #2 reset_n = 1'b1;
        setin(1'b1, 16'hCA00, 1'b1, 1'b0, 3'd0, 16'h0);
        #1 chk("postrst_rdy", 16'(in_ready), 16'h1);
        tick();
        chk("postrst_ar", ar, 16'h0);
        chk("postrst_br", br, 16'h0);
        setin(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
